// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents:
//   state_t  - sequencer state (RUN, WAIT, ERR)
//   ctrl_t   - packed bundle of all pipeline-register write-enable/clear strobes
//   CTRL_*   - the fixed strobe patterns used by the output mux
package pipe_hazard_ctrl_pkg;

  localparam int XZR_IDX = 31;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_wren;
    logic if_id_wren;
    logic if_id_flush;
    logic id_ex_wren;
    logic id_ex_flush;
    logic ex_mem_wren;
    logic ex_mem_flush;
    logic mem_wb_wren;
  } ctrl_t;

  // Reset: hold everything and clear every register that has a clear strobe.
  localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  // Full freeze: nothing moves, nothing is cleared.
  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Taken branch: everything advances, the three younger stages are squashed.
  localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  // Load-use: hold PC and IF_ID, drop a bubble into ID_EX, let older stages drain.
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  // Normal flow.
  localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-register control bundle driven by the hazard controller.
// Signals: per-stage write-enables (pc, if_id, id_ex, ex_mem, mem_wb) and
// synchronous-clear strobes (if_id, id_ex, ex_mem).
// Modports: master = controller (drives), slave = pipeline datapath (consumes).
interface pipe_hazard_ctrl_if;
  logic pc_wren;
  logic if_id_wren;
  logic if_id_flush;
  logic id_ex_wren;
  logic id_ex_flush;
  logic ex_mem_wren;
  logic ex_mem_flush;
  logic mem_wb_wren;

  modport master (
    output pc_wren, if_id_wren, if_id_flush, id_ex_wren,
           id_ex_flush, ex_mem_wren, ex_mem_flush, mem_wb_wren
  );

  modport slave (
    input  pc_wren, if_id_wren, if_id_flush, id_ex_wren,
           id_ex_flush, ex_mem_wren, ex_mem_flush, mem_wb_wren
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator (purely combinational).
// Ports:
//   id_rn, id_rm, id_uses_rm - source operands of the instruction in ID
//   ex_rd, ex_mem_read, ex_valid - destination/type of the instruction in EX
//   hit - ID must stall one cycle waiting for the EX load result
module pipe_hazard_ctrl_load_use_detect #(
  parameter int REG_W = 5,
  parameter int XZR   = 31
) (
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_uses_rm,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  output logic             hit
);
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [REG_W-1:0] XZR_V = REG_W'(XZR);

  logic rn_match;
  logic rm_match;

  assign rn_match = (ex_rd == id_rn);
  // id_rm is only a real operand when the ID instruction actually reads it
  assign rm_match = id_uses_rm && (ex_rd == id_rm);
  // The zero register is never written, so a load targeting it creates no dependency
  assign hit      = ex_valid && ex_mem_read && (ex_rd != XZR_V) && (rn_match || rm_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   id_rn/id_rm/id_uses_rm  - ID-stage source operands
//   ex_rd/ex_mem_read/ex_valid - EX-stage destination and load flag
//   br_taken                - taken branch resolved in MEM
//   dmem_busy               - data memory not ready, freeze request
//   bus (master)            - write-enables and clear strobes of all pipeline registers
//   err                     - sticky watchdog error (memory wait too long)
//   stall_cnt, flush_cnt    - saturating performance counters
// Control strobes are combinational from state and inputs; state and counters are registered.
module pipe_hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int XZR      = pipe_hazard_ctrl_pkg::XZR_IDX,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [REG_W-1:0]   id_rn,
  input  logic [REG_W-1:0]   id_rm,
  input  logic               id_uses_rm,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_valid,
  input  logic               br_taken,
  input  logic               dmem_busy,
  pipe_hazard_ctrl_if.master bus,
  output logic               err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait;
  logic              hit;
  logic              stall_inc;
  logic              flush_inc;
  ctrl_t             ctrl_next;
  ctrl_t             ctrl_out;

  pipe_hazard_ctrl_load_use_detect #(
    .REG_W (REG_W),
    .XZR   (XZR)
  ) u_load_use (
    .id_rn       (id_rn),
    .id_rm       (id_rm),
    .id_uses_rm  (id_uses_rm),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_valid    (ex_valid),
    .hit         (hit)
  );

  // State register and memory-wait watchdog counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait;
    end
  end

  // Next-state, watchdog and strobe selection in priority order: freeze, branch, load-use
  always_comb begin
    next_state = state;
    next_wait  = wait_cnt;
    ctrl_next  = CTRL_FREEZE;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state)
      RUN, WAIT: begin
        if (dmem_busy) begin
          // A pending br_taken is held by the frozen EX_MEM, so it is replayed once busy drops
          ctrl_next = CTRL_FREEZE;
          stall_inc = 1'b1;
          if (state == RUN) begin
            next_state = WAIT;
            next_wait  = WAIT_W'(1);
          end else if (wait_cnt >= MAX_WAIT_V) begin
            next_state = ERR;
          end else begin
            next_wait = wait_cnt + WAIT_W'(1);
          end
        end else begin
          next_state = RUN;
          next_wait  = '0;
          if (br_taken) begin
            // The instruction causing any load-use hit is squashed anyway
            ctrl_next = CTRL_BRANCH;
            flush_inc = 1'b1;
          end else if (hit) begin
            ctrl_next = CTRL_LOAD_USE;
            stall_inc = 1'b1;
          end else begin
            ctrl_next = CTRL_RUN;
          end
        end
      end
      ERR: begin
        ctrl_next = CTRL_FREEZE;
      end
      default: begin
        // Unreachable encoding: park safely with the pipeline frozen
        next_state = ERR;
        ctrl_next  = CTRL_FREEZE;
      end
    endcase
  end

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // While reset is held the strobes clear the pipeline regardless of state
  assign ctrl_out = reset ? CTRL_RESET : ctrl_next;
  assign err      = (state == ERR);

  assign bus.pc_wren      = ctrl_out.pc_wren;
  assign bus.if_id_wren   = ctrl_out.if_id_wren;
  assign bus.if_id_flush  = ctrl_out.if_id_flush;
  assign bus.id_ex_wren   = ctrl_out.id_ex_wren;
  assign bus.id_ex_flush  = ctrl_out.id_ex_flush;
  assign bus.ex_mem_wren  = ctrl_out.ex_mem_wren;
  assign bus.ex_mem_flush = ctrl_out.ex_mem_flush;
  assign bus.mem_wb_wren  = ctrl_out.mem_wb_wren;

endmodule
